// File: rtl/brg_pkg.sv
// Shared definitions for the system bridge: FSM encoding, error read value
// and the default timer/UART/GPIO address windows.
package brg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } brg_state_t;

  localparam logic [31:0] RD_DEFAULT_C = 32'h0002_3333;

  // Device 0 in the least significant word.
  localparam logic [95:0] DEF_DEV_BASE  = {32'h0000_7F20, 32'h0000_7F10, 32'h0000_7F00};
  localparam logic [95:0] DEF_DEV_LIMIT = {32'h0000_7F3F, 32'h0000_7F1B, 32'h0000_7F0B};

endpackage

// File: rtl/brg_addr_decode.sv
// Combinational address decoder: inclusive unsigned windows, lowest index
// wins when windows overlap.
module brg_addr_decode #(
  parameter int                    N_DEV     = 3,
  parameter logic [N_DEV*32-1:0]   DEV_BASE  = brg_pkg::DEF_DEV_BASE,
  parameter logic [N_DEV*32-1:0]   DEV_LIMIT = brg_pkg::DEF_DEV_LIMIT
) (
  input  logic [31:0]      addr,
  output logic [N_DEV-1:0] sel,
  output logic             hit
);

  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < N_DEV; i++) begin
      if (!hit && (addr >= DEV_BASE[i*32 +: 32]) && (addr <= DEV_LIMIT[i*32 +: 32])) begin
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sys_bridge_n.sv
// CPU-to-peripheral bridge: one transaction in flight, req/ack towards the
// devices, registered response with error flag for unmapped or timed-out accesses.
//
// Handshake: a processor request is taken only in a cycle where pr_req=1 and
// pr_busy=0; completion is the single cycle with pr_ack=1, in which pr_rd and
// pr_err are valid. Towards devices, dev_sel is held until the selected dev_ack
// is sampled high at a clock edge or the timeout expires.
module sys_bridge_n
  import brg_pkg::*;
#(
  parameter int                  N_DEV      = 3,
  parameter logic [N_DEV*32-1:0] DEV_BASE   = DEF_DEV_BASE,
  parameter logic [N_DEV*32-1:0] DEV_LIMIT  = DEF_DEV_LIMIT,
  parameter int                  TIMEOUT    = 16,
  parameter logic [31:0]         RD_DEFAULT = RD_DEFAULT_C
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pr_req,
  input  logic [31:0]           pr_addr,
  input  logic [31:0]           pr_wd,
  input  logic                  pr_we,
  input  logic [3:0]            pr_be,
  output logic                  pr_busy,
  output logic                  pr_ack,
  output logic [31:0]           pr_rd,
  output logic                  pr_err,
  output logic [31:0]           pr_err_addr,
  output logic [N_DEV-1:0]      dev_sel,
  output logic [31:0]           dev_addr,
  output logic [31:0]           dev_wd,
  output logic [3:0]            dev_be,
  output logic                  dev_we,
  input  logic [N_DEV*32-1:0]   dev_rd,
  input  logic [N_DEV-1:0]      dev_ack,
  output logic [1:0]            dbg_state
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  brg_state_t     state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [N_DEV-1:0] dec_sel;
  logic           dec_hit;
  logic           ack_hit;
  logic           tmo_hit;
  logic [31:0]    rd_mux;

  brg_addr_decode #(
    .N_DEV    (N_DEV),
    .DEV_BASE (DEV_BASE),
    .DEV_LIMIT(DEV_LIMIT)
  ) u_decode (
    .addr(pr_addr),
    .sel (dec_sel),
    .hit (dec_hit)
  );

  // Only the selected device's ack counts; others are masked out.
  assign ack_hit = |(dev_ack & dev_sel);
  assign tmo_hit = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (dev_sel[i]) rd_mux = rd_mux | dev_rd[i*32 +: 32];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pr_req) state_nxt = dec_hit ? ST_WAIT : ST_RESP;
      ST_WAIT: if (ack_hit || tmo_hit) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      dev_sel     <= '0;
      dev_we      <= 1'b0;
      dev_addr    <= '0;
      dev_wd      <= '0;
      dev_be      <= '0;
      pr_rd       <= '0;
      pr_err      <= 1'b0;
      pr_err_addr <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (pr_req) begin
            dev_addr <= pr_addr;
            dev_wd   <= pr_wd;
            dev_be   <= pr_be;
            cnt      <= '0;
            if (dec_hit) begin
              dev_sel <= dec_sel;
              dev_we  <= pr_we;
            end else begin
              pr_err      <= 1'b1;
              pr_rd       <= RD_DEFAULT;
              pr_err_addr <= pr_addr;
            end
          end
        end
        ST_WAIT: begin
          if (ack_hit) begin
            pr_rd   <= dev_we ? 32'h0 : rd_mux;
            pr_err  <= 1'b0;
            dev_sel <= '0;
            dev_we  <= 1'b0;
          end else if (tmo_hit) begin
            pr_rd       <= RD_DEFAULT;
            pr_err      <= 1'b1;
            pr_err_addr <= dev_addr;
            dev_sel     <= '0;
            dev_we      <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pr_ack    = (state == ST_RESP);
  assign pr_busy   = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_sys_bridge_n.sv
// Directed bench for sys_bridge_n: hits, slow write, unmapped, timeout,
// window boundaries, busy behaviour and reset during WAIT.
module tb_sys_bridge_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        pr_req;
  logic [31:0] pr_addr;
  logic [31:0] pr_wd;
  logic        pr_we;
  logic [3:0]  pr_be;
  logic        pr_busy;
  logic        pr_ack;
  logic [31:0] pr_rd;
  logic        pr_err;
  logic [31:0] pr_err_addr;
  logic [2:0]  dev_sel;
  logic [31:0] dev_addr;
  logic [31:0] dev_wd;
  logic [3:0]  dev_be;
  logic        dev_we;
  logic [95:0] dev_rd;
  logic [2:0]  dev_ack;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  sys_bridge_n dut (
    .clk        (clk),
    .reset      (reset),
    .pr_req     (pr_req),
    .pr_addr    (pr_addr),
    .pr_wd      (pr_wd),
    .pr_we      (pr_we),
    .pr_be      (pr_be),
    .pr_busy    (pr_busy),
    .pr_ack     (pr_ack),
    .pr_rd      (pr_rd),
    .pr_err     (pr_err),
    .pr_err_addr(pr_err_addr),
    .dev_sel    (dev_sel),
    .dev_addr   (dev_addr),
    .dev_wd     (dev_wd),
    .dev_be     (dev_be),
    .dev_we     (dev_we),
    .dev_rd     (dev_rd),
    .dev_ack    (dev_ack),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver: present a request for one cycle; it is accepted at the next edge.
  task automatic issue(input logic [31:0] addr, input logic [31:0] wd,
                       input logic we, input logic [3:0] be);
    pr_req  = 1'b1;
    pr_addr = addr;
    pr_wd   = wd;
    pr_we   = we;
    pr_be   = be;
    tick();
    pr_req  = 1'b0;
  endtask

  // Scoreboard: compare the response in the current (pr_ack) cycle.
  task automatic expect_resp(input string tag, input logic exp_err);
    logic [31:0] exp_rd;
    check({tag, "_ack"}, {31'h0, pr_ack}, 32'h1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      exp_rd = exp_q.pop_front();
      check({tag, "_rd"}, pr_rd, exp_rd);
    end
    check({tag, "_err"}, {31'h0, pr_err}, {31'h0, exp_err});
  endtask

  initial begin
    int n;
    reset   = 1'b1;
    pr_req  = 1'b0;
    pr_addr = '0;
    pr_wd   = '0;
    pr_we   = 1'b0;
    pr_be   = '0;
    dev_rd  = '0;
    dev_ack = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_busy", {31'h0, pr_busy}, 32'h0);
    check("rst_ack", {31'h0, pr_ack}, 32'h0);
    check("rst_rd", pr_rd, 32'h0);
    check("rst_err_addr", pr_err_addr, 32'h0);
    check("rst_sel", {29'h0, dev_sel}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);

    // Read timer1 with ack in the first WAIT cycle
    dev_rd[63:32] = 32'h0000_1234;
    exp_q.push_back(32'h0000_1234);
    issue(32'h7F14, 32'h0, 1'b0, 4'hF);
    check("t1_sel", {29'h0, dev_sel}, 32'h2);
    check("t1_busy", {31'h0, pr_busy}, 32'h1);
    check("t1_addr", dev_addr, 32'h7F14);
    check("t1_we", {31'h0, dev_we}, 32'h0);
    check("t1_ack_early", {31'h0, pr_ack}, 32'h0);
    dev_ack = 3'b010;
    tick();
    dev_ack = 3'b000;
    expect_resp("t1", 1'b0);
    check("t1_sel_drop", {29'h0, dev_sel}, 32'h0);
    tick();
    check("t1_idle", {31'h0, pr_busy}, 32'h0);
    check("t1_rd_hold", pr_rd, 32'h0000_1234);

    // Write dev2, slow ack, other devices acking meanwhile
    dev_rd[95:64] = 32'hFFFF_FFFF;
    exp_q.push_back(32'h0);
    issue(32'h7F20, 32'hDEAD_BEEF, 1'b1, 4'b0011);
    dev_ack = 3'b011;
    for (int i = 0; i < 5; i++) begin
      check("t2_sel", {29'h0, dev_sel}, 32'h4);
      check("t2_we", {31'h0, dev_we}, 32'h1);
      check("t2_wd", dev_wd, 32'hDEAD_BEEF);
      check("t2_be", {28'h0, dev_be}, 32'h3);
      check("t2_busy", {31'h0, pr_busy}, 32'h1);
      tick();
    end
    check("t2_still_wait", {30'h0, dbg_state}, 32'h1);
    dev_ack = 3'b100;
    tick();
    dev_ack = 3'b000;
    expect_resp("t2", 1'b0);
    check("t2_busy_resp", {31'h0, pr_busy}, 32'h1);
    check("t2_we_drop", {31'h0, dev_we}, 32'h0);
    tick();

    // Unmapped address in the gap after device 0
    exp_q.push_back(32'h0002_3333);
    issue(32'h7F0C, 32'h0, 1'b0, 4'hF);
    expect_resp("t3", 1'b1);
    check("t3_sel", {29'h0, dev_sel}, 32'h0);
    check("t3_err_addr", pr_err_addr, 32'h7F0C);
    tick();

    // Timeout on device 0 while non-selected devices ack
    exp_q.push_back(32'h0002_3333);
    issue(32'h7F00, 32'h0, 1'b0, 4'hF);
    dev_ack = 3'b110;
    n = 0;
    for (int c = 0; c < 40 && !pr_ack; c++) begin
      if (dev_sel == 3'b001) n++;
      tick();
    end
    dev_ack = 3'b000;
    check("t4_wait_cycles", n, 32'd16);
    expect_resp("t4", 1'b1);
    check("t4_err_addr", pr_err_addr, 32'h7F00);
    check("t4_sel_drop", {29'h0, dev_sel}, 32'h0);
    tick();

    // Upper edge of device 0
    dev_rd[31:0] = 32'hA5A5_0000;
    exp_q.push_back(32'hA5A5_0000);
    issue(32'h7F0B, 32'h0, 1'b0, 4'hF);
    check("t5a_sel", {29'h0, dev_sel}, 32'h1);
    dev_ack = 3'b001;
    tick();
    dev_ack = 3'b000;
    expect_resp("t5a", 1'b0);
    tick();

    // Lower edge of device 1 with pr_req held through WAIT, then 0x7F1C
    // requested in the RESP cycle is taken on the following IDLE cycle.
    dev_rd[63:32] = 32'h0000_5678;
    exp_q.push_back(32'h0000_5678);
    pr_req  = 1'b1;
    pr_addr = 32'h7F10;
    pr_we   = 1'b0;
    tick();
    check("t5b_sel", {29'h0, dev_sel}, 32'h2);
    pr_addr = 32'h7F00;
    tick();
    tick();
    check("t5b_held_sel", {29'h0, dev_sel}, 32'h2);
    check("t5b_held_addr", dev_addr, 32'h7F10);
    dev_ack = 3'b010;
    tick();
    dev_ack = 3'b000;
    expect_resp("t5b", 1'b0);
    pr_addr = 32'h7F1C;
    exp_q.push_back(32'h0002_3333);
    tick();
    check("t5c_idle", {31'h0, pr_busy}, 32'h0);
    tick();
    pr_req = 1'b0;
    expect_resp("t5c", 1'b1);
    check("t5c_err_addr", pr_err_addr, 32'h7F1C);
    tick();

    // Async reset in the middle of WAIT
    issue(32'h7F00, 32'h0, 1'b0, 4'hF);
    check("t6_sel_pre", {29'h0, dev_sel}, 32'h1);
    reset = 1'b1;
    #1;
    check("t6_sel_rst", {29'h0, dev_sel}, 32'h0);
    check("t6_busy_rst", {31'h0, pr_busy}, 32'h0);
    check("t6_ack_rst", {31'h0, pr_ack}, 32'h0);
    #2;
    reset = 1'b0;
    tick();
    check("t6_no_ack", {31'h0, pr_ack}, 32'h0);
    dev_rd[31:0] = 32'hCAFE_0001;
    exp_q.push_back(32'hCAFE_0001);
    issue(32'h7F04, 32'h0, 1'b0, 4'hF);
    check("t6_sel", {29'h0, dev_sel}, 32'h1);
    dev_ack = 3'b001;
    tick();
    dev_ack = 3'b000;
    expect_resp("t6", 1'b0);
    tick();

    check("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
